// File: rtl/mycpu_pkg.sv
// Shared CPU-side types for the memory-mapped I/O unit: register map,
// timer FSM encoding, STATUS bit positions and an address-decode helper.
package mycpu_pkg;

  typedef enum logic [2:0] {
    IO_GPIO_OUT  = 3'd0,
    IO_GPIO_IN   = 3'd1,
    IO_TMR_CNT   = 3'd2,
    IO_TMR_CMP   = 3'd3,
    IO_TMR_CTRL  = 3'd4,
    IO_STATUS    = 3'd5,
    IO_IRQ_MASK  = 3'd6,
    IO_RSVD      = 3'd7
  } io_addr_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_RUN  = 2'b01,
    T_DONE = 2'b10
  } timer_state_t;

  localparam int STAT_TMR_BIT  = 0;
  localparam int STAT_EDGE_BIT = 1;

  // Only the eight lowest addresses are backed by registers.
  function automatic logic io_is_mapped(input logic [15:0] addr);
    return (addr[15:3] == 13'd0);
  endfunction

endpackage

// File: rtl/io_timer.sv
// Compare timer for io_unit: prescaler, IDLE/RUN/DONE FSM and 16-bit counter.
// Only compiled when IO_UNIT_TIMER_EN is defined.
`ifdef IO_UNIT_TIMER_EN
module io_timer
  import mycpu_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ctrl_we,
  input  logic         ctrl_en,
  input  logic         reload,
  input  logic [15:0]  cmp,
  output logic [15:0]  cnt,
  output timer_state_t state,
  output logic         expire
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  timer_state_t state_r;
  timer_state_t state_nxt_s;
  logic [15:0]  cnt_r;
  logic [15:0]  presc_r;
  logic         tick_s;
  logic         match_s;
  logic         start_s;
  logic         stop_s;
  logic         cnt_clr_s;
  logic         cnt_inc_s;
  logic         presc_clr_s;
  logic         expire_s;

  assign tick_s  = (state_r == T_RUN) && (presc_r == PRESC_LAST);
  assign match_s = (cnt_r == cmp);
  assign start_s = ctrl_we & ctrl_en;
  assign stop_s  = ctrl_we & ~ctrl_en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= T_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a CTRL write overrides whatever the FSM was doing.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = T_RUN;
    end else if (stop_s) begin
      state_nxt_s = T_IDLE;
    end else begin
      case (state_r)
        T_IDLE: state_nxt_s = T_IDLE;
        T_RUN: begin
          if (tick_s && match_s && !reload) begin
            state_nxt_s = T_DONE;
          end else begin
            state_nxt_s = T_RUN;
          end
        end
        T_DONE:  state_nxt_s = T_DONE;
        default: state_nxt_s = T_IDLE;
      endcase
    end
  end

  // Output logic: counter/prescaler controls and the expiry pulse.
  always_comb begin
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    presc_clr_s = 1'b0;
    expire_s    = 1'b0;
    if (start_s) begin
      cnt_clr_s   = 1'b1;
      presc_clr_s = 1'b1;
    end else if (stop_s) begin
      presc_clr_s = 1'b1;
    end else if (tick_s) begin
      if (match_s) begin
        expire_s  = 1'b1;
        cnt_clr_s = reload;
      end else begin
        cnt_inc_s = 1'b1;
      end
    end else begin
      cnt_clr_s = 1'b0;
    end
  end

  // Counter and prescaler; CNT naturally wraps FFFF->0 when CMP was set below it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 16'h0000;
      presc_r <= 16'h0000;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= 16'h0000;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 16'h0001;
      end
      if (presc_clr_s || tick_s) begin
        presc_r <= 16'h0000;
      end else if (state_r == T_RUN) begin
        presc_r <= presc_r + 16'h0001;
      end
    end
  end

  assign cnt    = cnt_r;
  assign state  = state_r;
  assign expire = expire_s;

endmodule
`endif

// File: rtl/io_unit.sv
// Memory-mapped I/O responder for IOR/IOW: GPIO, input edge detector,
// optional compare timer (build with IO_UNIT_TIMER_EN) and a level interrupt.
// Read data is combinational so the register file captures it in EX0.
module io_unit
  import mycpu_pkg::*;
#(
  parameter int GPIO_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iom_in,
  input  logic              wen_in,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq_out
);

  io_addr_t     reg_sel_s;
  logic         wr_s;
  logic [GPIO_W-1:0] gpio_out_r;
  logic [GPIO_W-1:0] sync1_r;
  logic [GPIO_W-1:0] sync2_r;
  logic [GPIO_W-1:0] prev_r;
  logic [1:0]   stat_r;
  logic [1:0]   stat_nxt_s;
  logic [1:0]   mask_r;
  logic         edge_s;
  logic         tmr_set_s;
  logic [15:0]  tmr_cnt_s;
  logic [15:0]  tmr_cmp_s;
  logic [1:0]   tmr_ctrl_s;
  timer_state_t tmr_state_s;
  logic [15:0]  rd_s;

  assign reg_sel_s = io_addr_t'(addr_in[2:0]);
  assign wr_s      = iom_in & ~wen_in & io_is_mapped(addr_in);
  assign edge_s    = |(sync2_r & ~prev_r);

`ifdef IO_UNIT_TIMER_EN
  logic [15:0] cmp_r;
  logic [1:0]  ctrl_r;

  // Timer configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_r  <= 16'h0000;
      ctrl_r <= 2'b00;
    end else begin
      if (wr_s && (reg_sel_s == IO_TMR_CMP)) begin
        cmp_r <= data_in;
      end
      if (wr_s && (reg_sel_s == IO_TMR_CTRL)) begin
        ctrl_r <= data_in[1:0];
      end
    end
  end

  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ctrl_we (wr_s && (reg_sel_s == IO_TMR_CTRL)),
    .ctrl_en (data_in[0]),
    .reload  (ctrl_r[1]),
    .cmp     (cmp_r),
    .cnt     (tmr_cnt_s),
    .state   (tmr_state_s),
    .expire  (tmr_set_s)
  );

  assign tmr_cmp_s  = cmp_r;
  assign tmr_ctrl_s = ctrl_r;
`else
  logic unused_s;

  assign tmr_cnt_s   = 16'h0000;
  assign tmr_cmp_s   = 16'h0000;
  assign tmr_ctrl_s  = 2'b00;
  assign tmr_state_s = T_IDLE;
  assign tmr_set_s   = 1'b0;
  assign unused_s    = ^{data_in, (PRESCALE > 0)};
`endif

  // Two-flop input synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // STATUS flags: hardware set beats a same-cycle write-one-to-clear.
  always_comb begin
    stat_nxt_s = stat_r;
    if (wr_s && (reg_sel_s == IO_STATUS)) begin
      stat_nxt_s = stat_r & ~data_in[1:0];
    end else begin
      stat_nxt_s = stat_r;
    end
    if (tmr_set_s) begin
      stat_nxt_s[STAT_TMR_BIT] = 1'b1;
    end else begin
      stat_nxt_s[STAT_TMR_BIT] = stat_nxt_s[STAT_TMR_BIT];
    end
    if (edge_s) begin
      stat_nxt_s[STAT_EDGE_BIT] = 1'b1;
    end else begin
      stat_nxt_s[STAT_EDGE_BIT] = stat_nxt_s[STAT_EDGE_BIT];
    end
  end

  // Software-visible registers: GPIO output, STATUS and IRQ mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_r <= '0;
      stat_r     <= 2'b00;
      mask_r     <= 2'b00;
    end else begin
      stat_r <= stat_nxt_s;
      if (wr_s && (reg_sel_s == IO_GPIO_OUT)) begin
        gpio_out_r <= data_in[GPIO_W-1:0];
      end
      if (wr_s && (reg_sel_s == IO_IRQ_MASK)) begin
        mask_r <= data_in[1:0];
      end
    end
  end

  // Combinational read mux; narrow GPIO values are zero-extended.
  always_comb begin
    rd_s = 16'h0000;
    if (iom_in && io_is_mapped(addr_in)) begin
      case (reg_sel_s)
        IO_GPIO_OUT: rd_s[GPIO_W-1:0] = gpio_out_r;
        IO_GPIO_IN:  rd_s[GPIO_W-1:0] = sync2_r;
        IO_TMR_CNT:  rd_s = tmr_cnt_s;
        IO_TMR_CMP:  rd_s = tmr_cmp_s;
        IO_TMR_CTRL: rd_s = {14'h0000, tmr_ctrl_s};
        IO_STATUS:   rd_s = {12'h000, tmr_state_s, stat_r};
        IO_IRQ_MASK: rd_s = {14'h0000, mask_r};
        IO_RSVD:     rd_s = 16'h0000;
        default:     rd_s = 16'h0000;
      endcase
    end else begin
      rd_s = 16'h0000;
    end
  end

  assign data_out = rd_s;
  assign gpio_out = gpio_out_r;
  assign irq_out  = |(stat_r & mask_r);

endmodule
